gfx_fb_nbuf_writer: RTL and testbench
=====================================

// Module: gfx_fb_nbuf_writer
// PURPOSE
//  Producer-side frame buffer front end for N-buffered graphics (N = 2 or 3).
//  Takes (x, y, color, meta) pixels, clips them to the frame and maps each one to a flat SRAM address in the current draw buffer.
//  Queues pixels to the fb writer and rotates draw/display buffers on request, aligned to the display frame boundary.
//  Sits between the gfx producer and fb_writer; disp_base feeds the display read side.
// PARAMETERS
//  FB_WIDTH        640  visible pixels per line
//  FB_HEIGHT       480  visible lines per frame
//  PIXEL_BITS      12   color bits per pixel
//  META_BITS       4    meta bits per pixel
//  AXI_ADDR_WIDTH  20   SRAM word address width
//  NUM_BUFS        2    frame buffers, 2..3; NUM_BUFS*FB_WIDTH*FB_HEIGHT must be <= 2**AXI_ADDR_WIDTH (elaboration error otherwise)
//  FIFO_DEPTH      4    pixel queue entries; power of two, >= 2
//  VSYNC_POL       0    disp_vsync active level (0 = active-low)
// PORTS
//  clk           in   1               system clock
//  rst_n         in   1               async active-low reset
//  gfx_x         in   clog2(FB_WIDTH)   pixel x
//  gfx_y         in   clog2(FB_HEIGHT)  pixel y
//  gfx_color     in   PIXEL_BITS      pixel color
//  gfx_meta      in   META_BITS       pixel meta
//  gfx_valid     in   1               pixel valid
//  gfx_ready     out  1               pixel accepted when valid & ready
//  swap_req      in   1               request buffer rotation, sampled in DRAW only
//  swap_pending  out  1               high from request until rotation
//  swap_done     out  1               1-cycle pulse on rotation
//  disp_vsync    in   1               vsync from the display pixel stream
//  wr_addr       out  AXI_ADDR_WIDTH  fb write word address
//  wr_data       out  PIXEL_BITS+META_BITS  {color, meta}
//  wr_valid      out  1               write valid
//  wr_ready      in   1               write ready
//  draw_buf      out  clog2(NUM_BUFS) buffer receiving writes
//  disp_buf      out  clog2(NUM_BUFS) buffer being displayed
//  disp_base     out  AXI_ADDR_WIDTH  disp_buf*FB_WIDTH*FB_HEIGHT
//  clip_count    out  16              dropped out-of-range pixels, saturating
// BEHAVIOUR
//  Reset (async, any state; queue contents discarded):
//   - state = DRAW, FIFO empty.
//   - wr_valid = 0, swap_pending = 0, swap_done = 0, clip_count = 0.
//   - draw_buf = 1, disp_buf = 0, gfx_ready = 1.
//  Input acceptance:
//   - gfx_ready = (state == DRAW) & !fifo_full. fifo_full is registered; there is no same-cycle pop bypass.
//   - Accepted in-range pixel: address = draw_buf*FB_WIDTH*FB_HEIGHT + gfx_y*FB_WIDTH + gfx_x. It is pushed with data {color, meta}.
//   - Out-of-range pixel (x >= FB_WIDTH or y >= FB_HEIGHT): the handshake completes, but the pixel is dropped and clip_count increments (holds at 16'hFFFF).
//  Output:
//   - Registered FIFO output; a pixel accepted in cycle t reaches wr_valid no earlier than t+1.
//   - In-order delivery.
//   - wr_addr and wr_data hold stable while wr_valid & !wr_ready.
//  FSM:
//   - DRAW -> DRAIN when swap_req = 1. gfx_ready drops the next cycle.
//   - DRAIN -> WAIT_VS when the FIFO is empty and wr_valid = 0.
//   - WAIT_VS -> DRAW on an active edge of disp_vsync (inactive->active, VSYNC_POL-aware, previous sample registered). The edge counts only when sampled while in WAIT_VS.
//   - On WAIT_VS -> DRAW: disp_buf <= draw_buf; draw_buf <= (draw_buf+1) mod NUM_BUFS; swap_done = 1 for that cycle.
//   - swap_pending = (state != DRAW).
//   - swap_req outside DRAW is ignored.
//   - disp_base follows disp_buf in the same cycle (combinational).
//  Simultaneous events:
//   - Push and pop in the same cycle keep the occupancy unchanged.
//   - A vsync edge in the same cycle as DRAIN -> WAIT_VS is not counted; wait for the next edge.
// TESTING
//  - Reset, pixel (3,2,12'hABC,4'h5), wr_ready = 1 -> wr_addr = 307200+1283 = 308483, wr_data = 16'hABC5, one beat.
//  - Pixels (640,0) and (0,480) -> both accepted; no wr_valid; clip_count = 2.
//  - wr_ready = 0, 6 valid pixels -> 4 accepted, gfx_ready = 0. Then wr_ready = 1 -> 4 in-order beats with data held stable under stall.
//  - swap_req with 2 queued -> gfx_ready = 0 until drained. On the next vsync fall: swap_done pulse, draw_buf = 0, disp_buf = 1, disp_base = 307200.
//  - NUM_BUFS = 3, three swaps -> draw_buf 1 -> 2 -> 0 -> 1 and disp_buf 0 -> 1 -> 2 -> 0.
//  - rst_n low in WAIT_VS with a vsync edge pending -> all reset values; no swap_done.

Source files
------------

// File: rtl/gfx_fb_nbuf_writer.sv
// N-buffered frame buffer front end: clips and addresses producer pixels, queues them
// to the fb writer and rotates draw/display buffers on a display vsync edge.
module gfx_fb_nbuf_writer #(
    parameter int FB_WIDTH       = 640,
    parameter int FB_HEIGHT      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int META_BITS      = 4,
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int NUM_BUFS       = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int VSYNC_POL      = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [$clog2(FB_WIDTH)-1:0]        gfx_x,
    input  logic [$clog2(FB_HEIGHT)-1:0]       gfx_y,
    input  logic [PIXEL_BITS-1:0]              gfx_color,
    input  logic [META_BITS-1:0]               gfx_meta,
    input  logic                               gfx_valid,
    output logic                               gfx_ready,
    input  logic                               swap_req,
    output logic                               swap_pending,
    output logic                               swap_done,
    input  logic                               disp_vsync,
    output logic [AXI_ADDR_WIDTH-1:0]          wr_addr,
    output logic [PIXEL_BITS+META_BITS-1:0]    wr_data,
    output logic                               wr_valid,
    input  logic                               wr_ready,
    output logic [$clog2(NUM_BUFS)-1:0]        draw_buf,
    output logic [$clog2(NUM_BUFS)-1:0]        disp_buf,
    output logic [AXI_ADDR_WIDTH-1:0]          disp_base,
    output logic [15:0]                        clip_count
);

    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int BW    = $clog2(NUM_BUFS);
    localparam int DW    = PIXEL_BITS + META_BITS;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int FRAME = FB_WIDTH * FB_HEIGHT;

    localparam logic [1:0] ST_DRAW    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_WAIT_VS = 2'd2;

    if (NUM_BUFS < 2 || NUM_BUFS > 3) begin : g_bad_num_bufs
        $error("gfx_fb_nbuf_writer: NUM_BUFS must be 2 or 3");
    end
    if (longint'(NUM_BUFS) * longint'(FRAME) > (longint'(1) << AXI_ADDR_WIDTH)) begin : g_bad_addr_space
        $error("gfx_fb_nbuf_writer: frame buffers do not fit in the SRAM address space");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
        $error("gfx_fb_nbuf_writer: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [1:0]    state;
    logic [1:0]    state_next;
    logic [AW-1:0] mem_addr [FIFO_DEPTH];
    logic [DW-1:0] mem_data [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          fifo_full;
    logic          in_range;
    logic          accept;
    logic          push;
    logic          pop;
    logic [AW-1:0] pix_addr;
    logic          vs_active;
    logic          vs_prev;
    logic          vs_edge;
    logic          rotate;

    always_comb begin
        in_range   = (32'(gfx_x) < FB_WIDTH) && (32'(gfx_y) < FB_HEIGHT);
        accept     = gfx_valid && gfx_ready;
        push       = accept && in_range;
        pop        = wr_valid && wr_ready;
        count_next = count + (PW+1)'(push) - (PW+1)'(pop);
        pix_addr   = AW'(draw_buf) * AW'(FRAME) + AW'(gfx_y) * AW'(FB_WIDTH) + AW'(gfx_x);
        vs_active  = (disp_vsync == 1'(VSYNC_POL));
        vs_edge    = vs_active && !vs_prev;
        rotate     = (state == ST_WAIT_VS) && vs_edge;
    end

    // The DRAIN exit looks only at the registered occupancy, so a vsync edge seen
    // in that same cycle is never counted.
    always_comb begin
        state_next = state;
        case (state)
            ST_DRAW:    if (swap_req) state_next = ST_DRAIN;
            ST_DRAIN:   if (count == '0 && !wr_valid) state_next = ST_WAIT_VS;
            ST_WAIT_VS: if (vs_edge) state_next = ST_DRAW;
            default:    state_next = ST_DRAW;
        endcase
    end

    assign gfx_ready    = (state == ST_DRAW) && !fifo_full;
    assign swap_pending = (state != ST_DRAW);
    assign wr_addr      = mem_addr[rd_ptr];
    assign wr_data      = mem_data[rd_ptr];
    assign disp_base    = AW'(disp_buf) * AW'(FRAME);

    // Queue storage carries no reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr] <= pix_addr;
            mem_data[wr_ptr] <= {gfx_color, gfx_meta};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            wr_valid  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count     <= count_next;
            fifo_full <= (count_next == (PW+1)'(FIFO_DEPTH));
            wr_valid  <= (count_next != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clip_count <= '0;
        end else if (accept && !in_range && clip_count != 16'hFFFF) begin
            clip_count <= clip_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_DRAW;
            vs_prev   <= 1'b0;
            swap_done <= 1'b0;
            draw_buf  <= BW'(1);
            disp_buf  <= '0;
        end else begin
            state     <= state_next;
            vs_prev   <= vs_active;
            swap_done <= rotate;
            if (rotate) begin
                disp_buf <= draw_buf;
                draw_buf <= (draw_buf == BW'(NUM_BUFS - 1)) ? '0 : draw_buf + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_gfx_fb_nbuf_writer.sv
// Scoreboard bench for gfx_fb_nbuf_writer: a 2-buffer instance for the pixel path and
// swap flow, plus a 3-buffer instance for buffer rotation order.
module tb_gfx_fb_nbuf_writer;

    localparam int FRAME = 640 * 480;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  gfxX;
    logic [8:0]  gfxY;
    logic [11:0] gfxColor;
    logic [3:0]  gfxMeta;
    logic        gfxValid;
    logic        gfxReady;
    logic        swapReq;
    logic        swapPending;
    logic        swapDone;
    logic        vsync;
    logic [19:0] wrAddr;
    logic [15:0] wrData;
    logic        wrValid;
    logic        wrReady;
    logic        drawBuf;
    logic        dispBuf;
    logic [19:0] dispBase;
    logic [15:0] clipCount;

    logic [9:0]  gfxX3;
    logic [8:0]  gfxY3;
    logic [11:0] gfxColor3;
    logic [3:0]  gfxMeta3;
    logic        gfxValid3;
    logic        gfxReady3;
    logic        swapReq3;
    logic        swapPending3;
    logic        swapDone3;
    logic        vsync3;
    logic [19:0] wrAddr3;
    logic [15:0] wrData3;
    logic        wrValid3;
    logic        wrReady3;
    logic [1:0]  drawBuf3;
    logic [1:0]  dispBuf3;
    logic [19:0] dispBase3;
    logic [15:0] clipCount3;

    int totalCount = 0;
    int badCount   = 0;
    int beatCount  = 0;
    int drawModel  = 1;
    logic [35:0] sbq[$];

    gfx_fb_nbuf_writer dut (
        .clk(clk), .rst_n(rst_n),
        .gfx_x(gfxX), .gfx_y(gfxY), .gfx_color(gfxColor), .gfx_meta(gfxMeta),
        .gfx_valid(gfxValid), .gfx_ready(gfxReady),
        .swap_req(swapReq), .swap_pending(swapPending), .swap_done(swapDone),
        .disp_vsync(vsync),
        .wr_addr(wrAddr), .wr_data(wrData), .wr_valid(wrValid), .wr_ready(wrReady),
        .draw_buf(drawBuf), .disp_buf(dispBuf), .disp_base(dispBase), .clip_count(clipCount)
    );

    gfx_fb_nbuf_writer #(.NUM_BUFS(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .gfx_x(gfxX3), .gfx_y(gfxY3), .gfx_color(gfxColor3), .gfx_meta(gfxMeta3),
        .gfx_valid(gfxValid3), .gfx_ready(gfxReady3),
        .swap_req(swapReq3), .swap_pending(swapPending3), .swap_done(swapDone3),
        .disp_vsync(vsync3),
        .wr_addr(wrAddr3), .wr_data(wrData3), .wr_valid(wrValid3), .wr_ready(wrReady3),
        .draw_buf(drawBuf3), .disp_buf(dispBuf3), .disp_base(dispBase3), .clip_count(clipCount3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic nextCycle(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one pixel for one cycle; the expected beat is queued only if it will be accepted and kept.
    task automatic applyStimulus(input int px, input int py, input logic [11:0] c, input logic [3:0] m,
                                 output logic acc);
        gfxX     = 10'(px);
        gfxY     = 9'(py);
        gfxColor = c;
        gfxMeta  = m;
        gfxValid = 1'b1;
        @(negedge clk);
        acc = gfxReady;
        if (acc && px < 640 && py < 480)
            sbq.push_back({20'(drawModel * FRAME + py * 640 + px), c, m});
        nextCycle();
        gfxValid = 1'b0;
    endtask

    task automatic waitDrain();
        int budget = 200;
        while (sbq.size() != 0 && budget > 0) begin
            nextCycle();
            budget--;
        end
        checkOutput("drainDone", 64'(sbq.size()), 64'(0));
    endtask

    // Output monitor: pops the scoreboard on each beat and checks that a stalled beat holds still.
    logic        stallHeld = 1'b0;
    logic [35:0] heldBeat;
    always @(negedge clk) begin
        if (!rst_n) begin
            stallHeld = 1'b0;
        end else begin
            if (stallHeld) begin
                checkOutput("stallValid", 64'(wrValid), 64'(1));
                checkOutput("stallBeat", 64'({wrAddr, wrData}), 64'(heldBeat));
            end
            if (wrValid && wrReady) begin
                if (sbq.size() == 0) begin
                    checkOutput("spuriousBeat", 64'(1), 64'(0));
                end else begin
                    logic [35:0] exp;
                    exp = sbq.pop_front();
                    checkOutput("beatAddr", 64'(wrAddr), 64'(exp[35:16]));
                    checkOutput("beatData", 64'(wrData), 64'(exp[15:0]));
                end
                beatCount++;
                stallHeld = 1'b0;
            end else if (wrValid) begin
                stallHeld = 1'b1;
                heldBeat  = {wrAddr, wrData};
            end else begin
                stallHeld = 1'b0;
            end
        end
    end

    initial begin
        logic acc;
        int   accCount;
        int   beatsBefore;
        int   expDraw3 [3] = '{2, 0, 1};
        int   expDisp3 [3] = '{1, 2, 0};

        rst_n = 1'b0;
        gfxX = '0; gfxY = '0; gfxColor = '0; gfxMeta = '0; gfxValid = 1'b0;
        swapReq = 1'b0; vsync = 1'b1; wrReady = 1'b1;
        gfxX3 = '0; gfxY3 = '0; gfxColor3 = '0; gfxMeta3 = '0; gfxValid3 = 1'b0;
        swapReq3 = 1'b0; vsync3 = 1'b1; wrReady3 = 1'b1;

        repeat (2) @(negedge clk);
        checkOutput("rstReady", 64'(gfxReady), 64'(1));
        checkOutput("rstWrValid", 64'(wrValid), 64'(0));
        checkOutput("rstPending", 64'(swapPending), 64'(0));
        checkOutput("rstDone", 64'(swapDone), 64'(0));
        checkOutput("rstClip", 64'(clipCount), 64'(0));
        checkOutput("rstDrawBuf", 64'(drawBuf), 64'(1));
        checkOutput("rstDispBuf", 64'(dispBuf), 64'(0));
        checkOutput("rstDispBase", 64'(dispBase), 64'(0));
        checkOutput("rstReady3", 64'(gfxReady3), 64'(1));
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // Single pixel lands in buffer 1 at 307200 + 2*640 + 3.
        applyStimulus(3, 2, 12'hABC, 4'h5, acc);
        checkOutput("firstAccept", 64'(acc), 64'(1));
        checkOutput("firstAddrModel", 64'(sbq[0][35:16]), 64'(308483));
        waitDrain();
        nextCycle(2);
        checkOutput("firstBeats", 64'(beatCount), 64'(1));

        // Out-of-range pixels complete the handshake but are dropped.
        beatsBefore = beatCount;
        applyStimulus(640, 0, 12'h111, 4'h1, acc);
        checkOutput("clipAcceptX", 64'(acc), 64'(1));
        applyStimulus(0, 480, 12'h222, 4'h2, acc);
        checkOutput("clipAcceptY", 64'(acc), 64'(1));
        nextCycle(3);
        checkOutput("clipCount", 64'(clipCount), 64'(2));
        checkOutput("clipNoBeat", 64'(beatCount), 64'(beatsBefore));

        // Stalled writer: only FIFO_DEPTH pixels fit, then they drain in order.
        wrReady  = 1'b0;
        accCount = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(100 + i, 10 + i, 12'(12'h300 + i), 4'(i), acc);
            if (acc) accCount++;
        end
        @(negedge clk);
        checkOutput("fullAccepted", 64'(accCount), 64'(4));
        checkOutput("fullReady", 64'(gfxReady), 64'(0));
        nextCycle();
        beatsBefore = beatCount;
        wrReady = 1'b1;
        waitDrain();
        nextCycle(2);
        checkOutput("fullBeats", 64'(beatCount - beatsBefore), 64'(4));

        // Swap with two pixels queued behind a stalled writer.
        wrReady = 1'b0;
        applyStimulus(10, 20, 12'h5A5, 4'h3, acc);
        applyStimulus(11, 20, 12'hA5A, 4'hC, acc);
        swapReq = 1'b1;
        nextCycle();
        swapReq = 1'b0;
        @(negedge clk);
        checkOutput("drainReady", 64'(gfxReady), 64'(0));
        checkOutput("drainPending", 64'(swapPending), 64'(1));
        nextCycle();
        applyStimulus(12, 20, 12'hFFF, 4'hF, acc);
        checkOutput("drainReject", 64'(acc), 64'(0));
        wrReady = 1'b1;
        waitDrain();
        nextCycle(3);
        checkOutput("waitPending", 64'(swapPending), 64'(1));
        checkOutput("waitNoDone", 64'(swapDone), 64'(0));
        checkOutput("waitDrawBuf", 64'(drawBuf), 64'(1));
        vsync = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("swapDone", 64'(swapDone), 64'(1));
        checkOutput("swapDrawBuf", 64'(drawBuf), 64'(0));
        checkOutput("swapDispBuf", 64'(dispBuf), 64'(1));
        checkOutput("swapDispBase", 64'(dispBase), 64'(FRAME));
        checkOutput("swapPendingLow", 64'(swapPending), 64'(0));
        nextCycle();
        vsync = 1'b1;
        @(negedge clk);
        checkOutput("swapDonePulse", 64'(swapDone), 64'(0));
        nextCycle();
        drawModel = 0;
        applyStimulus(1, 1, 12'h0F0, 4'h7, acc);
        checkOutput("buf0Addr", 64'(sbq[0][35:16]), 64'(641));
        waitDrain();
        nextCycle(2);

        // Three-buffer rotation order.
        for (int i = 0; i < 3; i++) begin
            swapReq3 = 1'b1;
            nextCycle();
            swapReq3 = 1'b0;
            @(negedge clk);
            checkOutput("rot3Pending", 64'(swapPending3), 64'(1));
            nextCycle(3);
            vsync3 = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput("rot3Done", 64'(swapDone3), 64'(1));
            checkOutput("rot3DrawBuf", 64'(drawBuf3), 64'(expDraw3[i]));
            checkOutput("rot3DispBuf", 64'(dispBuf3), 64'(expDisp3[i]));
            checkOutput("rot3DispBase", 64'(dispBase3), 64'(expDisp3[i] * FRAME));
            nextCycle();
            vsync3 = 1'b1;
            nextCycle();
        end
        gfxX3 = 10'd5; gfxY3 = 9'd0; gfxColor3 = 12'h123; gfxMeta3 = 4'hA; gfxValid3 = 1'b1;
        nextCycle();
        gfxValid3 = 1'b0;
        @(negedge clk);
        checkOutput("rot3WrValid", 64'(wrValid3), 64'(1));
        checkOutput("rot3WrAddr", 64'(wrAddr3), 64'(FRAME + 5));
        checkOutput("rot3WrData", 64'(wrData3), 64'(16'h123A));
        checkOutput("rot3Clip", 64'(clipCount3), 64'(0));
        nextCycle(2);

        // Reset lands while waiting for vsync with an edge about to be seen.
        swapReq = 1'b1;
        nextCycle();
        swapReq = 1'b0;
        nextCycle(4);
        vsync = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rstWaitDone", 64'(swapDone), 64'(0));
        checkOutput("rstWaitPending", 64'(swapPending), 64'(0));
        checkOutput("rstWaitDrawBuf", 64'(drawBuf), 64'(1));
        checkOutput("rstWaitDispBuf", 64'(dispBuf), 64'(0));
        checkOutput("rstWaitClip", 64'(clipCount), 64'(0));
        checkOutput("rstWaitReady", 64'(gfxReady), 64'(1));
        nextCycle();
        rst_n = 1'b1;
        nextCycle(2);
        @(negedge clk);
        checkOutput("postRstDone", 64'(swapDone), 64'(0));
        checkOutput("postRstDrawBuf", 64'(drawBuf), 64'(1));
        checkOutput("postRstWrValid", 64'(wrValid), 64'(0));
        vsync = 1'b1;
        nextCycle(2);

        checkOutput("sbEmpty", 64'(sbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
